key_event_queue: RTL and testbench

//  Downstream of the keyboard scanner: consumes the 40-bit keysCurrentState vector from the IO key/display block.

---
 rtl/dpc_kb_pkg.sv | 28 ++
 rtl/key_event_queue_if.sv | 22 ++
 rtl/key_event_fifo.sv | 63 ++++++
 rtl/key_event_queue.sv | 134 +++++++++++++
 tb/tb_key_event_queue.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dpc_kb_pkg.sv
// Shared types for the keyboard event path.
// Event layout and scan FSM states.
package dpc_kb_pkg;

  localparam int KEY_NUM_MAX = 64;
  localparam int CODE_W      = 6;

  typedef struct packed {
    logic              released;
    logic [CODE_W-1:0] code;
  } key_event_t;

  typedef enum logic {
    KQ_IDLE,
    KQ_SCAN
  } kq_state_t;

  function automatic key_event_t make_event(
    input logic              released,
    input logic [CODE_W-1:0] code
  );
    key_event_t ev;
    ev.released = released;
    ev.code     = code;
    return ev;
  endfunction

endpackage

// File: rtl/key_event_queue_if.sv
// Event handshake bundle between the key queue
// and its consumer (DPC core / UART side).
interface key_event_queue_if;
  import dpc_kb_pkg::*;

  key_event_t event_o;
  logic       event_valid_o;
  logic       event_ready_i;

  modport master (
    output event_o,
    output event_valid_o,
    input  event_ready_i
  );

  modport slave (
    input  event_o,
    input  event_valid_o,
    output event_ready_i
  );

endinterface

// File: rtl/key_event_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Full-push policy and drop accounting live in the parent.
module key_event_fifo
  import dpc_kb_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = key_event_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  T                         wdata,
  output T                         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? T'('0) : mem[rd_ptr];

  // Storage is not reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/key_event_queue.sv
// Debounces the key state vector, scans accepted changes
// into press/release events and queues them for the consumer.
module key_event_queue
  import dpc_kb_pkg::*;
#(
  parameter int KEY_NUM          = 40,
  parameter int DEBOUNCE_SAMPLES = 4,
  parameter int FIFO_DEPTH       = 8
) (
  input  logic                          Clock_1us,
  input  logic                          Rst,
  input  logic                          sample_en_i,
  input  logic [KEY_NUM-1:0]            keysCurrentState,
  input  logic                          clear_i,
  key_event_queue_if.master             evq,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          overflow_o,
  output logic                          busy_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SAMPLES);
  localparam logic [CODE_W-1:0] IDX_LAST = CODE_W'(KEY_NUM - 1);

  logic [KEY_NUM-1:0] raw_q;
  logic [KEY_NUM-1:0] deb_q;
  logic [KEY_NUM-1:0] new_q;
  logic [KEY_NUM-1:0] pending_q;
  logic [CNT_W-1:0]   stable_cnt;
  logic [CODE_W-1:0]  idx_q;

  kq_state_t state_q;
  kq_state_t state_d;

  logic       accept;
  logic       scan_push;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_push;
  logic       fifo_pop;
  key_event_t push_ev;
  key_event_t head_ev;

  always_ff @(posedge Clock_1us) begin
    if (Rst) begin
      state_q <= KQ_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    scan_push = 1'b0;
    busy_o    = 1'b0;
    unique case (state_q)
      KQ_IDLE: begin
        if (stable_cnt == CNT_MAX && raw_q != deb_q) begin
          accept  = 1'b1;
          state_d = KQ_SCAN;
        end
      end
      KQ_SCAN: begin
        busy_o    = 1'b1;
        scan_push = pending_q[idx_q];
        if (idx_q == IDX_LAST) begin
          state_d = KQ_IDLE;
        end
      end
    endcase
  end

  // Sampling keeps running during a scan so a later change is not lost.
  always_ff @(posedge Clock_1us) begin
    if (Rst) begin
      raw_q      <= '0;
      deb_q      <= '0;
      new_q      <= '0;
      pending_q  <= '0;
      stable_cnt <= '0;
      idx_q      <= '0;
    end else begin
      if (sample_en_i) begin
        if (keysCurrentState != raw_q) begin
          raw_q      <= keysCurrentState;
          stable_cnt <= CNT_W'(1);
        end else if (stable_cnt != CNT_MAX) begin
          stable_cnt <= stable_cnt + CNT_W'(1);
        end
      end
      if (accept) begin
        pending_q <= raw_q ^ deb_q;
        new_q     <= raw_q;
        deb_q     <= raw_q;
        idx_q     <= '0;
      end else if (state_q == KQ_SCAN) begin
        idx_q <= idx_q + CODE_W'(1);
      end
    end
  end

  assign push_ev   = make_event(~new_q[idx_q], idx_q);
  assign fifo_pop  = evq.event_valid_o & evq.event_ready_i;
  assign fifo_push = scan_push & (~fifo_full | fifo_pop) & ~clear_i;

  key_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (key_event_t)
  ) u_fifo (
    .clk   (Clock_1us),
    .rst   (Rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clear (clear_i),
    .wdata (push_ev),
    .rdata (head_ev),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count_o)
  );

  assign evq.event_o       = head_ev;
  assign evq.event_valid_o = ~fifo_empty;

  always_ff @(posedge Clock_1us) begin
    if (Rst || clear_i) begin
      overflow_o <= 1'b0;
    end else if (scan_push && fifo_full && !fifo_pop) begin
      overflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_key_event_queue.sv
// Directed self-checking bench for key_event_queue.
// Default parameters: 40 keys, 4 debounce samples, 8-deep FIFO.
module tb_key_event_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_en = 1'b0;
  logic [39:0] keys = '0;
  logic        clear = 1'b0;
  logic [3:0]  count;
  logic        ovf;
  logic        busy;

  int errors = 0;
  int checks = 0;

  key_event_queue_if evq ();

  key_event_queue dut (
    .Clock_1us        (clk),
    .Rst              (rst),
    .sample_en_i      (sample_en),
    .keysCurrentState (keys),
    .clear_i          (clear),
    .evq              (evq),
    .fifo_count_o     (count),
    .overflow_o       (ovf),
    .busy_o           (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_sample(input logic [39:0] v);
    @(negedge clk);
    keys      = v;
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
  endtask

  task automatic hold(input logic [39:0] v, input int n);
    repeat (n) do_sample(v);
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 42 && !ok; i++) begin
      @(negedge clk);
      if (evq.event_valid_o) ok = 1'b1;
    end
  endtask

  task automatic wait_busy(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 6 && !ok; i++) begin
      @(negedge clk);
      if (busy) ok = 1'b1;
    end
  endtask

  task automatic wait_idle(output bit ok);
    repeat (2) @(negedge clk);
    ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      if (!busy) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic pop_one();
    @(negedge clk);
    evq.event_ready_i = 1'b1;
    @(negedge clk);
    evq.event_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    evq.event_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({evq.event_o, evq.event_valid_o, count, ovf, busy} !== 14'h0) begin
      errors++;
      $display("FAIL reset_outputs: got ev=%h v=%b cnt=%0d ovf=%b busy=%b want all 0",
               evq.event_o, evq.event_valid_o, count, ovf, busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_press_release();
    bit ok;
    hold(40'h1 << 5, 4);
    wait_valid(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL t1_press_latency: got no valid want valid within 42 clocks");
    end
    checks++;
    if (evq.event_o !== 7'h05) begin
      errors++;
      $display("FAIL t1_press_event: got %h want 05", evq.event_o);
    end
    wait_idle(ok);
    checks++;
    if (count !== 4'd1) begin
      errors++;
      $display("FAIL t1_press_count: got %0d want 1", count);
    end
    pop_one();
    hold(40'h0, 4);
    wait_valid(ok);
    checks++;
    if (!ok || evq.event_o !== 7'h45) begin
      errors++;
      $display("FAIL t1_release_event: got %h (valid=%b) want 45", evq.event_o, ok);
    end
    pop_one();
    wait_idle(ok);
  endtask

  task automatic test_bounce();
    bit ok;
    for (int i = 0; i < 10; i++) begin
      do_sample((i % 2 == 0) ? (40'h1 << 12) : 40'h0);
    end
    hold(40'h1 << 12, 3);
    repeat (5) @(negedge clk);
    checks++;
    if (evq.event_valid_o !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL t2_bounce_quiet: got valid=%b busy=%b want 0 0",
               evq.event_valid_o, busy);
    end
    do_sample(40'h1 << 12);
    wait_valid(ok);
    checks++;
    if (!ok || evq.event_o !== 7'h0C) begin
      errors++;
      $display("FAIL t2_stable_event: got %h (valid=%b) want 0c", evq.event_o, ok);
    end
    wait_idle(ok);
    checks++;
    if (count !== 4'd1) begin
      errors++;
      $display("FAIL t2_single_event: got count %0d want 1", count);
    end
    pop_one();
    hold(40'h0, 4);
    wait_valid(ok);
    checks++;
    if (!ok || evq.event_o !== 7'h4C) begin
      errors++;
      $display("FAIL t2_release_event: got %h want 4c", evq.event_o);
    end
    pop_one();
    wait_idle(ok);
  endtask

  task automatic test_index_order();
    bit ok;
    hold((40'h1 << 39) | 40'h1, 4);
    wait_idle(ok);
    checks++;
    if (!ok || count !== 4'd2) begin
      errors++;
      $display("FAIL t3_two_events: got count %0d (idle=%b) want 2", count, ok);
    end
    checks++;
    if (evq.event_o !== 7'h00) begin
      errors++;
      $display("FAIL t3_first_key0: got %h want 00", evq.event_o);
    end
    pop_one();
    checks++;
    if (evq.event_o !== 7'h27) begin
      errors++;
      $display("FAIL t3_second_key39: got %h want 27", evq.event_o);
    end
    pop_one();
    hold(40'h0, 4);
    wait_idle(ok);
    checks++;
    if (evq.event_o !== 7'h40) begin
      errors++;
      $display("FAIL t3_release_key0: got %h want 40", evq.event_o);
    end
    pop_one();
    checks++;
    if (evq.event_o !== 7'h67) begin
      errors++;
      $display("FAIL t3_release_key39: got %h want 67", evq.event_o);
    end
    pop_one();
  endtask

  task automatic test_overflow_clear();
    bit ok;
    logic [39:0] v;
    v = '0;
    for (int k = 1; k <= 9; k++) begin
      v[k] = 1'b1;
      hold(v, 4);
      wait_idle(ok);
    end
    checks++;
    if (count !== 4'd8 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL t4_full_overflow: got count %0d ovf %b want 8 1", count, ovf);
    end
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if (evq.event_o !== 7'(k)) begin
        errors++;
        $display("FAIL t4_fifo_order: got %h want %h", evq.event_o, 7'(k));
      end
      pop_one();
    end
    checks++;
    if (count !== 4'd0 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL t4_sticky: got count %0d ovf %b want 0 1", count, ovf);
    end
    v[10] = 1'b1;
    hold(v, 4);
    wait_idle(ok);
    checks++;
    if (count !== 4'd1 || evq.event_o !== 7'h0A) begin
      errors++;
      $display("FAIL t4_pre_clear: got count %0d ev %h want 1 0a", count, evq.event_o);
    end
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++;
    if (count !== 4'd0 || ovf !== 1'b0 || evq.event_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL t4_clear: got count %0d ovf %b valid %b want 0 0 0",
               count, ovf, evq.event_valid_o);
    end
    evq.event_ready_i = 1'b1;
    hold(40'h0, 4);
    wait_idle(ok);
    repeat (3) @(negedge clk);
    checks++;
    if (count !== 4'd0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL t4_drain: got count %0d ovf %b want 0 0", count, ovf);
    end
    evq.event_ready_i = 1'b0;
  endtask

  task automatic test_full_push_pop();
    bit ok;
    logic [39:0] v;
    v = '0;
    for (int k = 1; k <= 8; k++) begin
      v[k] = 1'b1;
      hold(v, 4);
      wait_idle(ok);
    end
    checks++;
    if (count !== 4'd8 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL t5_filled: got count %0d ovf %b want 8 0", count, ovf);
    end
    v[0] = 1'b1;
    hold(v, 4);
    wait_busy(ok);
    evq.event_ready_i = 1'b1;
    @(negedge clk);
    evq.event_ready_i = 1'b0;
    checks++;
    if (!ok || count !== 4'd8 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL t5_push_pop_full: got count %0d ovf %b busy_seen %b want 8 0 1",
               count, ovf, ok);
    end
    wait_idle(ok);
    for (int k = 2; k <= 9; k++) begin
      checks++;
      if (evq.event_o !== ((k == 9) ? 7'h00 : 7'(k))) begin
        errors++;
        $display("FAIL t5_contents: got %h want %h", evq.event_o,
                 (k == 9) ? 7'h00 : 7'(k));
      end
      pop_one();
    end
    evq.event_ready_i = 1'b1;
    hold(40'h0, 4);
    wait_idle(ok);
    repeat (3) @(negedge clk);
    evq.event_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid_scan();
    bit ok;
    hold(40'h1 << 3, 4);
    wait_busy(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL t6_scan_start: got busy 0 want 1");
    end
    do_sample((40'h1 << 3) | (40'h1 << 20));
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL t6_still_scanning: got busy %b want 1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({evq.event_o, evq.event_valid_o, count, ovf, busy} !== 14'h0) begin
      errors++;
      $display("FAIL t6_reset_outputs: got ev=%h v=%b cnt=%0d ovf=%b busy=%b want all 0",
               evq.event_o, evq.event_valid_o, count, ovf, busy);
    end
    rst = 1'b0;
    repeat (50) @(negedge clk);
    checks++;
    if (evq.event_valid_o !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL t6_abandoned: got valid %b busy %b want 0 0",
               evq.event_valid_o, busy);
    end
    hold(40'h1 << 7, 4);
    wait_valid(ok);
    checks++;
    if (!ok || evq.event_o !== 7'h07) begin
      errors++;
      $display("FAIL t6_fresh_press: got %h (valid=%b) want 07", evq.event_o, ok);
    end
    wait_idle(ok);
    checks++;
    if (count !== 4'd1) begin
      errors++;
      $display("FAIL t6_fresh_count: got %0d want 1", count);
    end
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_bounce();
    test_index_order();
    test_overflow_clear();
    test_full_push_pop();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
